muldiv_issue: RTL

- Front-end sequencer between the EX stage and the iterative shift-add multiply/divide unit.
- Accepts one RV32M op (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) and converts the operands to unsigned magnitudes.
- Launches the unit, waits for it to finish, applies sign fix-up, and returns one 32-bit result.
- Stalls the pipeline for the whole operation. Handles divide-by-zero and signed overflow itself, without launching the unit.

---
 rtl/muldiv_issue_if.sv | 38 +++
 rtl/muldiv_issue.sv | 131 +++++++++++++
 2 files changed

// File: rtl/muldiv_issue_if.sv
// Signal bundle between the EX stage, the M-extension issue sequencer and the iterative mul/div unit.
// "master" is the sequencer's view; "slave" is the view of the EX stage plus the unit.
interface muldiv_issue_if #(
    parameter int XLEN = 32
);
    logic            md_valid;
    logic [2:0]      md_funct3;
    logic [XLEN-1:0] md_rs1;
    logic [XLEN-1:0] md_rs2;
    logic            md_flush;
    logic            md_stall;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    logic            unit_execute;
    logic            unit_div;
    logic [XLEN:0]   unit_opA;
    logic [XLEN:0]   unit_opB;
    logic            unit_sign_diff;
    logic            unit_stall;
    logic            unit_ready;
    logic [XLEN-1:0] unit_hi;
    logic [XLEN-1:0] unit_lo;

    modport master (
        input  md_valid, md_funct3, md_rs1, md_rs2, md_flush,
        input  unit_ready, unit_hi, unit_lo,
        output md_stall, md_done, md_result,
        output unit_execute, unit_div, unit_opA, unit_opB, unit_sign_diff, unit_stall
    );

    modport slave (
        output md_valid, md_funct3, md_rs1, md_rs2, md_flush,
        output unit_ready, unit_hi, unit_lo,
        input  md_stall, md_done, md_result,
        input  unit_execute, unit_div, unit_opA, unit_opB, unit_sign_diff, unit_stall
    );
endinterface

// File: rtl/muldiv_issue.sv
// RV32M issue sequencer: turns operands into magnitudes, launches the iterative unit,
// applies sign fix-up, and resolves divide-by-zero / signed overflow without the unit.
module muldiv_issue #(
    parameter int XLEN = 32
) (
    input  logic           Clk,
    input  logic           Reset_n,
    muldiv_issue_if.master bus
);
    typedef enum logic [2:0] {IDLE, FAST, LAUNCH, WAIT, FIXUP, DONE, DRAIN} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_reg, state_next;
    logic [2:0]      funct3_reg;
    logic [XLEN-1:0] rs1_reg, hi_reg, lo_reg, result_reg, result_next;
    logic [XLEN:0]   opa_reg, opb_reg;
    logic            sa_reg, sb_reg, sign_diff_reg;

    logic            signed_a, signed_b, in_div, in_sa, in_sb, in_fast, accept;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [2*XLEN-1:0] prod_fix;

    // MUL is treated as fully signed; the low half is identical either way.
    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (bus.md_funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            3'b010:  signed_a = 1'b1;
            default: ;
        endcase
    end

    assign in_div  = bus.md_funct3[2];
    assign in_sa   = signed_a & bus.md_rs1[XLEN-1];
    assign in_sb   = signed_b & bus.md_rs2[XLEN-1];
    assign mag_a   = in_sa ? -bus.md_rs1 : bus.md_rs1;
    assign mag_b   = in_sb ? -bus.md_rs2 : bus.md_rs2;
    assign in_fast = in_div & ((bus.md_rs2 == '0) |
                     (signed_b & (bus.md_rs1 == MIN_NEG) & (bus.md_rs2 == '1)));
    assign accept  = (state_reg == IDLE) & bus.md_valid & ~bus.md_flush;

    assign prod_fix = (sa_reg ^ sb_reg) ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE:   if (accept) state_next = in_fast ? FAST : LAUNCH;
            FAST: begin
                state_next = bus.md_flush ? IDLE : DONE;
                // A zero divisor magnitude can only mean divide-by-zero; otherwise signed overflow.
                if (opb_reg == '0)
                    result_next = funct3_reg[1] ? rs1_reg : '1;
                else
                    result_next = funct3_reg[1] ? '0 : MIN_NEG;
            end
            LAUNCH: state_next = bus.md_flush ? DRAIN : WAIT;
            WAIT: begin
                if (bus.md_flush)
                    state_next = bus.unit_ready ? IDLE : DRAIN;
                else if (bus.unit_ready)
                    state_next = FIXUP;
            end
            FIXUP: begin
                state_next = bus.md_flush ? IDLE : DONE;
                if (funct3_reg[2]) begin
                    if (!funct3_reg[1])
                        result_next = lo_reg;
                    else if (!funct3_reg[0])
                        result_next = sa_reg ? -hi_reg : hi_reg;
                    else
                        result_next = hi_reg;
                end else begin
                    result_next = (funct3_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                             : prod_fix[2*XLEN-1:XLEN];
                end
            end
            DONE:    state_next = IDLE;
            DRAIN:   if (bus.unit_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= IDLE;
            funct3_reg    <= '0;
            rs1_reg       <= '0;
            opa_reg       <= '0;
            opb_reg       <= '0;
            sa_reg        <= 1'b0;
            sb_reg        <= 1'b0;
            sign_diff_reg <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            result_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                funct3_reg    <= bus.md_funct3;
                rs1_reg       <= bus.md_rs1;
                opa_reg       <= {1'b0, mag_a};
                opb_reg       <= {1'b0, mag_b};
                sa_reg        <= in_sa;
                sb_reg        <= in_sb;
                sign_diff_reg <= in_div & (in_sa ^ in_sb);
            end
            if ((state_reg == WAIT) && bus.unit_ready) begin
                hi_reg <= bus.unit_hi;
                lo_reg <= bus.unit_lo;
            end
            if (((state_reg == FAST) || (state_reg == FIXUP)) && !bus.md_flush)
                result_reg <= result_next;
        end
    end

    assign bus.md_done        = (state_reg == DONE);
    assign bus.md_stall       = bus.md_valid & ~bus.md_done & ~bus.md_flush;
    assign bus.md_result      = result_reg;
    assign bus.unit_execute   = (state_reg == LAUNCH);
    assign bus.unit_div       = funct3_reg[2];
    assign bus.unit_opA       = opa_reg;
    assign bus.unit_opB       = opb_reg;
    assign bus.unit_sign_diff = sign_diff_reg;
    assign bus.unit_stall     = 1'b0;
endmodule
